// File: rtl/truncate_clusters_param.sv
// rtl/truncate_clusters_param.sv - segmented VPF priority truncator with per-frame load and overflow flag
module truncate_clusters_param #(
    parameter int MXVPF        = 1536,
    parameter int MXSEGS       = 16,
    parameter int FRAME_LEN    = 8,
    parameter int PRIORITY_MSB = 0,
    parameter int ADRB         = 11,
    parameter int PHB          = 3
) (
    input  logic             clock,
    input  logic             global_reset,
    input  logic [3:0]       delay,
    input  logic [MXVPF-1:0] vpfs_in,
    output logic [MXVPF-1:0] vpfs_out,
    output logic             pop_vld,
    output logic [ADRB-1:0]  pop_adr,
    output logic             frame_start,
    output logic             overflow,
    output logic [PHB-1:0]   phase
);

    localparam int SEGW = MXVPF / MXSEGS;

    if (MXVPF % MXSEGS != 0) begin : g_chk_segs
        $error("MXVPF must be an integer multiple of MXSEGS");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 16) begin : g_chk_frame
        $error("FRAME_LEN must be in 2..16");
    end
    if ((2 ** ADRB) < MXVPF) begin : g_chk_adrb
        $error("ADRB too narrow for MXVPF");
    end
    if ((2 ** PHB) < FRAME_LEN) begin : g_chk_phb
        $error("PHB too narrow for FRAME_LEN");
    end

    logic [15:0]      r_rst_sr;
    logic             r_rst;
    logic [MXVPF-1:0] r_vpf;
    logic             r_pop_vld;
    logic [ADRB-1:0]  r_pop_adr;
    logic             r_frame_start;
    logic             r_overflow;
    logic [PHB-1:0]   r_phase;

    logic [MXSEGS-1:0] w_seg_act;
    logic [MXSEGS-1:0] w_seg_sel;
    logic [ADRB-1:0]   w_seg_adr [MXSEGS];
    logic [MXVPF-1:0]  w_vpf_next;
    logic [ADRB-1:0]   w_adr;
    logic              w_hi_act;
    logic              w_any;

    // Reset alignment: tap the delay line, then one more register stage.
    always_ff @(posedge clock) begin
        r_rst_sr <= {r_rst_sr[14:0], global_reset};
        r_rst    <= r_rst_sr[delay];
    end

    for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
        logic [SEGW-1:0] w_ord;
        logic [SEGW-1:0] w_iso;
        logic [SEGW-1:0] w_ord_clr;
        logic [SEGW-1:0] w_clr_nat;
        logic [ADRB-1:0] w_idx;

        // MSB mode works on the bit-reversed segment so the same isolate trick applies.
        always_comb begin
            w_ord = '0;
            for (int b = 0; b < SEGW; b++) begin
                w_ord[b] = (PRIORITY_MSB != 0) ? r_vpf[s*SEGW + SEGW - 1 - b] : r_vpf[s*SEGW + b];
            end
        end

        assign w_seg_act[s] = |w_ord;
        assign w_iso        = w_ord & (~w_ord + SEGW'(1));
        assign w_ord_clr    = w_ord & ~w_iso;

        always_comb begin
            w_clr_nat = '0;
            w_idx     = '0;
            for (int b = 0; b < SEGW; b++) begin
                w_clr_nat[b] = (PRIORITY_MSB != 0) ? w_ord_clr[SEGW - 1 - b] : w_ord_clr[b];
                if (w_iso[b]) begin
                    w_idx = ADRB'((PRIORITY_MSB != 0) ? (SEGW - 1 - b) : b);
                end
            end
        end

        assign w_seg_adr[s] = ADRB'(s * SEGW) + w_idx;
        assign w_vpf_next[s*SEGW +: SEGW] = w_seg_sel[s] ? w_clr_nat : r_vpf[s*SEGW +: SEGW];
    end

    // Only the highest-priority active segment strips; all others pass through.
    always_comb begin
        w_seg_sel = '0;
        w_hi_act  = 1'b0;
        w_adr     = '0;
        for (int k = 0; k < MXSEGS; k++) begin
            w_seg_sel[(PRIORITY_MSB != 0) ? (MXSEGS - 1 - k) : k] =
                w_seg_act[(PRIORITY_MSB != 0) ? (MXSEGS - 1 - k) : k] & ~w_hi_act;
            w_hi_act = w_hi_act | w_seg_act[(PRIORITY_MSB != 0) ? (MXSEGS - 1 - k) : k];
        end
        for (int s = 0; s < MXSEGS; s++) begin
            w_adr = w_adr | (w_seg_sel[s] ? w_seg_adr[s] : '0);
        end
    end

    assign w_any = |w_seg_act;

    always_ff @(posedge clock) begin
        if (r_rst) begin
            r_phase       <= '0;
            r_vpf         <= '0;
            r_pop_vld     <= 1'b0;
            r_pop_adr     <= '0;
            r_frame_start <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_phase <= (r_phase == PHB'(FRAME_LEN - 1)) ? '0 : r_phase + PHB'(1);
            if (r_phase == '0) begin
                r_vpf         <= vpfs_in;
                r_pop_vld     <= 1'b0;
                r_pop_adr     <= '0;
                r_frame_start <= 1'b1;
                r_overflow    <= |r_vpf;
            end else begin
                r_vpf         <= w_vpf_next;
                r_pop_vld     <= w_any;
                r_pop_adr     <= w_adr;
                r_frame_start <= 1'b0;
                r_overflow    <= 1'b0;
            end
        end
    end

    assign vpfs_out    = r_vpf;
    assign pop_vld     = r_pop_vld;
    assign pop_adr     = r_pop_adr;
    assign frame_start = r_frame_start;
    assign overflow    = r_overflow;
    assign phase       = r_phase;

endmodule
